// File: rtl/vp_key_event_queue.sv
// vp_key_event_queue
//   Merges PS/2 key events and the numeric keypads of NUM_JOY gamepads into
//   one ordered stream of {ascii, released} events and buffers them in a
//   FIFO_DEPTH-entry queue with a show-ahead head and a read strobe.
//
// Ports
//   clk_i            system clock
//   res_n_i          asynchronous active-low reset
//   ps2_key_i[10:0]  [10] event toggle, [9] make, [8] extended (unused), [7:0] Set-2 code
//   joy_keys_i       keypad buttons, pad j key k at bit j*JOY_KEYS+k, active-high
//   rx_data_ready_o  queue non-empty, head valid
//   rx_ascii_o       head ASCII code
//   rx_released_o    head is a release (1) or a press (0)
//   rx_read_i        pop the head when the queue is non-empty
//   overflow_o       sticky: a PS/2 event was dropped because the queue was full
module vp_key_event_queue #(
  parameter int NUM_JOY    = 2,
  parameter int JOY_KEYS   = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         res_n_i,
  input  logic [10:0]                  ps2_key_i,
  input  logic [NUM_JOY*JOY_KEYS-1:0]  joy_keys_i,
  output logic                         rx_data_ready_o,
  output logic [7:0]                   rx_ascii_o,
  output logic                         rx_released_o,
  input  logic                         rx_read_i,
  output logic                         overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Set-2 make code to ASCII; bit 8 flags a mapped code.
  function automatic logic [8:0] ps2_to_ascii(input logic [7:0] code);
    logic [8:0] r;
    r = 9'h000;
    case (code)
      8'h16: r = 9'h131;  8'h1E: r = 9'h132;  8'h26: r = 9'h133;  8'h25: r = 9'h134;
      8'h2E: r = 9'h135;  8'h36: r = 9'h136;  8'h3D: r = 9'h137;  8'h3E: r = 9'h138;
      8'h46: r = 9'h139;  8'h45: r = 9'h130;
      8'h1C: r = 9'h161;  8'h32: r = 9'h162;  8'h21: r = 9'h163;  8'h23: r = 9'h164;
      8'h24: r = 9'h165;  8'h2B: r = 9'h166;  8'h34: r = 9'h167;  8'h33: r = 9'h168;
      8'h43: r = 9'h169;  8'h3B: r = 9'h16A;  8'h42: r = 9'h16B;  8'h4B: r = 9'h16C;
      8'h3A: r = 9'h16D;  8'h31: r = 9'h16E;  8'h44: r = 9'h16F;  8'h4D: r = 9'h170;
      8'h15: r = 9'h171;  8'h2D: r = 9'h172;  8'h1B: r = 9'h173;  8'h2C: r = 9'h174;
      8'h3C: r = 9'h175;  8'h2A: r = 9'h176;  8'h1D: r = 9'h177;  8'h22: r = 9'h178;
      8'h35: r = 9'h179;  8'h1A: r = 9'h17A;
      8'h29: r = 9'h120;  8'h79: r = 9'h12B;  8'h7B: r = 9'h12D;  8'h7C: r = 9'h12A;
      8'h4A: r = 9'h12F;  8'h55: r = 9'h13D;  8'h1F: r = 9'h111;  8'h27: r = 9'h112;
      8'h5A: r = 9'h10A;  8'h66: r = 9'h108;
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  // Keypad key k: "1".."9" for k = 0..8, "0" for k = 9.
  function automatic logic [7:0] joy_ascii(input int k);
    return (k < 9) ? 8'(49 + k) : 8'h30;
  endfunction

  // Extended-key flag carries no meaning for this keymap.
  logic unused_ext;
  assign unused_ext = ps2_key_i[8];

  // OR the same key across all pads.
  logic [JOY_KEYS-1:0] merged;
  for (genvar gi = 0; gi < JOY_KEYS; gi++) begin : g_merge
    logic [NUM_JOY-1:0] column;
    for (genvar gj = 0; gj < NUM_JOY; gj++) begin : g_pad
      assign column[gj] = joy_keys_i[gj*JOY_KEYS + gi];
    end
    assign merged[gi] = |column;
  end

  logic                init_reg, tog_reg, overflow_reg;
  logic [JOY_KEYS-1:0] prev_reg, pending_reg, pending_next;
  logic                stage_valid_reg, stage_valid_next;
  logic [8:0]          stage_reg, stage_next;
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [CW-1:0]       count_reg, count_next;
  logic [8:0]          head_reg, head_next;
  logic [8:0]          mem [FIFO_DEPTH];

  logic                ps2_event, pop, room, push, stage_drop, scan_hit;
  logic [8:0]          ps2_map, push_data;
  logic [7:0]          scan_ascii;
  logic                scan_rel;
  logic [JOY_KEYS-1:0] scan_onehot, clear_mask, changed;

  assign rd_ptr_inc = rd_ptr_reg + 1'b1;

  always_comb begin
    ps2_map   = ps2_to_ascii(ps2_key_i[7:0]);
    ps2_event = !init_reg && (ps2_key_i[10] != tog_reg);
    changed   = init_reg ? '0 : (merged ^ prev_reg);
    pop       = rx_read_i && (count_reg != '0);
    // A full queue still accepts a write when the head leaves on the same edge.
    room      = (count_reg != DEPTH_C) || pop;

    // Lowest pending keypad bit; release flag taken from the live key state
    // so a press+release before service collapses into one release.
    scan_hit    = 1'b0;
    scan_onehot = '0;
    scan_ascii  = 8'h00;
    scan_rel    = 1'b0;
    for (int k = 0; k < JOY_KEYS; k++) begin
      if (pending_reg[k] && !scan_hit) begin
        scan_hit       = 1'b1;
        scan_onehot[k] = 1'b1;
        scan_ascii     = joy_ascii(k);
        scan_rel       = ~merged[k];
      end
    end

    // Single write port: the staged PS/2 event wins over the keypad scanner.
    push       = 1'b0;
    push_data  = 9'h000;
    clear_mask = '0;
    stage_drop = 1'b0;
    if (stage_valid_reg) begin
      if (room) begin
        push      = 1'b1;
        push_data = stage_reg;
      end else begin
        stage_drop = 1'b1;
      end
    end else if (scan_hit && room) begin
      push       = 1'b1;
      push_data  = {scan_rel, scan_ascii};
      clear_mask = scan_onehot;
    end

    // New changes take precedence over the bit being serviced.
    pending_next = (pending_reg & ~clear_mask) | changed;

    // The stage lives one cycle: either written or dropped.
    stage_valid_next = ps2_event && ps2_map[8];
    stage_next       = stage_valid_next ? {~ps2_key_i[9], ps2_map[7:0]} : stage_reg;

    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    head_next = head_reg;
    if (push && ((count_reg == '0) || (pop && count_reg == CW'(1)))) begin
      head_next = push_data;
    end else if (pop && (count_reg > CW'(1))) begin
      head_next = mem[rd_ptr_inc];
    end else if (pop) begin
      head_next = 9'h000;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      init_reg        <= 1'b1;
      tog_reg         <= 1'b0;
      prev_reg        <= '0;
      pending_reg     <= '0;
      stage_valid_reg <= 1'b0;
      stage_reg       <= 9'h000;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      head_reg        <= 9'h000;
      overflow_reg    <= 1'b0;
    end else begin
      init_reg        <= 1'b0;
      tog_reg         <= ps2_key_i[10];
      prev_reg        <= merged;
      pending_reg     <= pending_next;
      stage_valid_reg <= stage_valid_next;
      stage_reg       <= stage_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_inc;
      count_reg       <= count_next;
      head_reg        <= head_next;
      overflow_reg    <= overflow_reg | stage_drop;
    end
  end

  assign rx_data_ready_o = (count_reg != '0);
  assign rx_ascii_o      = head_reg[7:0];
  assign rx_released_o   = head_reg[8];
  assign overflow_o      = overflow_reg;
endmodule

// File: tb/tb_vp_key_event_queue.sv
module tb_vp_key_event_queue;
  localparam int NJ = 2;
  localparam int JK = 10;
  localparam int D  = 4;

  logic             clk = 1'b0;
  logic             res_n = 1'b0;
  logic [10:0]      ps2_key = '0;
  logic [NJ*JK-1:0] joy = '0;
  logic             rd = 1'b0;
  logic             ready, rel, ovf;
  logic [7:0]       ascii;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vp_key_event_queue #(.NUM_JOY(NJ), .JOY_KEYS(JK), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .res_n_i(res_n), .ps2_key_i(ps2_key), .joy_keys_i(joy),
    .rx_data_ready_o(ready), .rx_ascii_o(ascii), .rx_released_o(rel),
    .rx_read_i(rd), .overflow_o(ovf)
  );

  // ---------------- reference tables ----------------
  localparam logic [7:0] LETTER_SC [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
    8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGIT_SC [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h45};
  localparam logic [7:0] MISC_SC  [10] = '{8'h29, 8'h79, 8'h7B, 8'h7C, 8'h4A, 8'h55, 8'h1F,
    8'h27, 8'h5A, 8'h66};
  localparam logic [7:0] MISC_ASC [10] = '{8'h20, 8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h3D, 8'h11,
    8'h12, 8'h0A, 8'h08};

  function automatic logic [7:0] key_ascii(input int k);
    return (k < 9) ? 8'(49 + k) : 8'h30;
  endfunction

  function automatic logic [8:0] map_code(input logic [7:0] c);
    for (int i = 0; i < 26; i++) if (LETTER_SC[i] == c) return {1'b1, 8'(97 + i)};
    for (int i = 0; i < 10; i++) if (DIGIT_SC[i] == c) return {1'b1, key_ascii(i)};
    for (int i = 0; i < 10; i++) if (MISC_SC[i] == c) return {1'b1, MISC_ASC[i]};
    return 9'h000;
  endfunction

  function automatic logic [JK-1:0] merge(input logic [NJ*JK-1:0] v);
    logic [JK-1:0] m;
    m = '0;
    for (int j = 0; j < NJ; j++)
      for (int k = 0; k < JK; k++) m[k] = m[k] | v[j*JK + k];
    return m;
  endfunction

  // ---------------- behavioural model (used by the random test) ----------------
  bit            m_init, m_sv, m_ovf;
  logic          m_tog;
  logic [JK-1:0] m_prev, m_pend;
  logic [8:0]    m_stage;
  logic [8:0]    m_q[$];

  task automatic model_reset();
    m_init = 1; m_sv = 0; m_ovf = 0; m_tog = 0; m_prev = '0; m_pend = '0;
    m_stage = '0; m_q.delete();
  endtask

  // One clock edge worth of queue behaviour, evaluated on the inputs at that edge.
  task automatic model_step();
    logic [JK-1:0] mg;
    logic [8:0]    mp;
    bit            do_pop, room, found;
    mg     = merge(joy);
    do_pop = rd && (m_q.size() != 0);
    room   = (m_q.size() < D) || do_pop;
    if (do_pop) void'(m_q.pop_front());
    if (m_sv) begin
      if (room) m_q.push_back(m_stage);
      else m_ovf = 1;
    end else if (m_pend != '0 && room) begin
      found = 0;
      for (int k = 0; k < JK; k++) begin
        if (m_pend[k] && !found) begin
          found = 1;
          m_q.push_back({~mg[k], key_ascii(k)});
          m_pend[k] = 1'b0;
        end
      end
    end
    m_sv = 0;
    if (m_init) begin
      m_init = 0;
    end else begin
      if (ps2_key[10] != m_tog) begin
        mp = map_code(ps2_key[7:0]);
        if (mp[8]) begin
          m_sv = 1;
          m_stage = {~ps2_key[9], mp[7:0]};
        end
      end
      m_pend = m_pend | (mg ^ m_prev);
    end
    m_tog  = ps2_key[10];
    m_prev = mg;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_ps2(input logic [7:0] code, input logic make, input logic ext);
    ps2_key = {~ps2_key[10], make, ext, code};
  endtask

  task automatic pop_one();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    res_n = 1'b0;
    repeat (2) @(negedge clk);
    res_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    joy = '0;
    joy[3] = 1'b1;
    send_ps2(8'h1C, 1'b1, 1'b0);
    do_reset();
    n_cmp++;
    if ({ready, rel, ascii, ovf} !== 11'h000) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 000", {ready, rel, ascii, ovf});
    end
    tick(5);
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_held_keys: ready %b want 0", ready); end
    joy[3] = 1'b0;
    tick(2);
    n_cmp++;
    if ({ready, rel, ascii} !== {1'b1, 1'b1, 8'h34}) begin
      n_bad++; $display("FAIL reset_release_4: got %h want %h", {ready, rel, ascii}, {1'b1, 1'b1, 8'h34});
    end
    pop_one();
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_drain: ready %b want 0", ready); end
  endtask

  task automatic test_ps2_burst();
    send_ps2(8'h1C, 1'b1, 1'b0);
    tick(1);
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL burst_latency: ready %b want 0", ready); end
    tick(1);
    n_cmp++;
    if ({ready, rel, ascii} !== {1'b1, 1'b0, 8'h61}) begin
      n_bad++; $display("FAIL burst_make: got %h want %h", {ready, rel, ascii}, {1'b1, 1'b0, 8'h61});
    end
    send_ps2(8'h1C, 1'b0, 1'b0);
    tick(2);
    n_cmp++;
    if ({ready, rel, ascii} !== {1'b1, 1'b0, 8'h61}) begin
      n_bad++; $display("FAIL burst_head_hold: got %h want %h", {ready, rel, ascii}, {1'b1, 1'b0, 8'h61});
    end
    pop_one();
    n_cmp++;
    if ({ready, rel, ascii} !== {1'b1, 1'b1, 8'h61}) begin
      n_bad++; $display("FAIL burst_break: got %h want %h", {ready, rel, ascii}, {1'b1, 1'b1, 8'h61});
    end
    pop_one();
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL burst_empty: ready %b want 0", ready); end
  endtask

  task automatic test_unmapped();
    send_ps2(8'h76, 1'b1, 1'b0);
    tick(3);
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL unmapped_76: ready %b want 0", ready); end
    send_ps2(8'h15, 1'b1, 1'b1);
    tick(2);
    n_cmp++;
    if ({ready, rel, ascii} !== {1'b1, 1'b0, 8'h71}) begin
      n_bad++; $display("FAIL extended_q: got %h want %h", {ready, rel, ascii}, {1'b1, 1'b0, 8'h71});
    end
    pop_one();
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL unmapped_empty: ready %b want 0", ready); end
  endtask

  task automatic test_joy_merge();
    joy[2] = 1'b1; joy[JK + 2] = 1'b1;
    tick(2);
    n_cmp++;
    if ({ready, rel, ascii} !== {1'b1, 1'b0, 8'h33}) begin
      n_bad++; $display("FAIL merge_press: got %h want %h", {ready, rel, ascii}, {1'b1, 1'b0, 8'h33});
    end
    pop_one();
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL merge_single: ready %b want 0", ready); end
    joy[2] = 1'b0;
    tick(3);
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL merge_held: ready %b want 0", ready); end
    joy[JK + 2] = 1'b0;
    tick(2);
    n_cmp++;
    if ({ready, rel, ascii} !== {1'b1, 1'b1, 8'h33}) begin
      n_bad++; $display("FAIL merge_release: got %h want %h", {ready, rel, ascii}, {1'b1, 1'b1, 8'h33});
    end
    pop_one();
  endtask

  task automatic test_simultaneous();
    logic [8:0] exp_ev [5];
    exp_ev = '{{1'b0, 8'h61}, {1'b0, 8'h31}, {1'b0, 8'h35}, {1'b1, 8'h31}, {1'b1, 8'h35}};
    send_ps2(8'h1C, 1'b1, 1'b0);
    joy[0] = 1'b1; joy[4] = 1'b1;
    tick(4);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({ready, rel, ascii} !== {1'b1, exp_ev[i]}) begin
        n_bad++; $display("FAIL simul_order%0d: got %h want %h", i, {ready, rel, ascii}, {1'b1, exp_ev[i]});
      end
      pop_one();
    end
    joy[0] = 1'b0; joy[4] = 1'b0;
    tick(3);
    for (int i = 3; i < 5; i++) begin
      n_cmp++;
      if ({ready, rel, ascii} !== {1'b1, exp_ev[i]}) begin
        n_bad++; $display("FAIL simul_release%0d: got %h want %h", i, {ready, rel, ascii}, {1'b1, exp_ev[i]});
      end
      pop_one();
    end
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL simul_empty: ready %b want 0", ready); end
  endtask

  task automatic test_full();
    logic [7:0] codes [4];
    logic [7:0] exp_a [4];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25};
    exp_a = '{8'h32, 8'h33, 8'h34, 8'h30};
    for (int i = 0; i < 4; i++) begin
      send_ps2(codes[i], 1'b1, 1'b0);
      tick(1);
    end
    tick(1);
    n_cmp++;
    if ({ovf, ready, rel, ascii} !== {1'b0, 1'b1, 1'b0, 8'h31}) begin
      n_bad++; $display("FAIL full_fill: got %h want %h", {ovf, ready, rel, ascii}, {1'b0, 1'b1, 1'b0, 8'h31});
    end
    send_ps2(8'h2E, 1'b1, 1'b0);
    tick(2);
    n_cmp++;
    if (ovf !== 1'b1) begin n_bad++; $display("FAIL full_overflow: ovf %b want 1", ovf); end
    joy[9] = 1'b1;
    tick(3);
    n_cmp++;
    if ({ready, rel, ascii} !== {1'b1, 1'b0, 8'h31}) begin
      n_bad++; $display("FAIL full_head: got %h want %h", {ready, rel, ascii}, {1'b1, 1'b0, 8'h31});
    end
    for (int i = 0; i < 4; i++) begin
      pop_one();
      n_cmp++;
      if ({ready, rel, ascii} !== {1'b1, 1'b0, exp_a[i]}) begin
        n_bad++; $display("FAIL full_drain%0d: got %h want %h", i, {ready, rel, ascii}, {1'b1, 1'b0, exp_a[i]});
      end
    end
    pop_one();
    n_cmp++;
    if ({ready, ovf} !== 2'b01) begin
      n_bad++; $display("FAIL full_empty_sticky: got %b want 01", {ready, ovf});
    end
    joy[9] = 1'b0;
    tick(2);
    pop_one();
  endtask

  task automatic test_reset_midop();
    send_ps2(8'h16, 1'b1, 1'b0); tick(1);
    send_ps2(8'h1E, 1'b1, 1'b0); tick(1);
    send_ps2(8'h26, 1'b1, 1'b0); tick(2);
    n_cmp++;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL midop_queued: ready %b want 1", ready); end
    joy[5] = 1'b1;
    #2;
    res_n = 1'b0;
    #1;
    n_cmp++;
    if ({ready, ovf} !== 2'b00) begin
      n_bad++; $display("FAIL midop_async_clear: got %b want 00", {ready, ovf});
    end
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    tick(5);
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL midop_no_spurious: ready %b want 0", ready); end
    joy[5] = 1'b0;
    tick(2);
    n_cmp++;
    if ({ready, rel, ascii} !== {1'b1, 1'b1, 8'h36}) begin
      n_bad++; $display("FAIL midop_release: got %h want %h", {ready, rel, ascii}, {1'b1, 1'b1, 8'h36});
    end
    pop_one();
  endtask

  task automatic test_random();
    logic [7:0] code;
    int         idx;
    joy = '0;
    rd  = 1'b0;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_cmp++;
      if (ready !== (m_q.size() != 0)) begin
        n_bad++; $display("FAIL rand_ready cyc%0d: got %b want %b", cyc, ready, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        n_cmp++;
        if ({rel, ascii} !== m_q[0]) begin
          n_bad++; $display("FAIL rand_head cyc%0d: got %h want %h", cyc, {rel, ascii}, m_q[0]);
        end
      end
      n_cmp++;
      if (ovf !== m_ovf) begin
        n_bad++; $display("FAIL rand_overflow cyc%0d: got %b want %b", cyc, ovf, m_ovf);
      end
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(2))
          0:       code = LETTER_SC[$urandom_range(25)];
          1:       code = DIGIT_SC[$urandom_range(9)];
          default: code = 8'($urandom);
        endcase
        send_ps2(code, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
      if ($urandom_range(5) == 0) begin
        idx = $urandom_range(NJ*JK - 1);
        joy[idx] = ~joy[idx];
      end
      rd = (cyc < 300) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      @(posedge clk);
      model_step();
      #1;
    end
    rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ps2_burst();
    test_unmapped();
    test_joy_merge();
    test_simultaneous();
    test_full();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
